// File: rtl/clk_rst_seq.sv
// Power-up sequencer: waits for a stable PLL lock, holds the core in reset for a
// fixed settle time, then releases it and produces divided pixel/CPU clock enables.
module clk_rst_seq #(
  parameter int HOLD_CYCLES = 1024,
  parameter int CE_PIX_DIV  = 3,
  parameter int CE_CPU_DIV  = 6
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic pll_locked,
  output logic core_reset,
  output logic ready,
  output logic ce_pix,
  output logic ce_cpu,
  output logic lock_lost
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int PIX_W  = (CE_PIX_DIV > 1) ? $clog2(CE_PIX_DIV) : 1;
  localparam int CPU_W  = (CE_CPU_DIV > 1) ? $clog2(CE_CPU_DIV) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(CE_PIX_DIV - 1);
  localparam logic [CPU_W-1:0]  CPU_LAST  = CPU_W'(CE_CPU_DIV - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  logic              r_sync1;
  logic              r_sync2;
  state_t            r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [PIX_W-1:0]  r_pix_cnt;
  logic [CPU_W-1:0]  r_cpu_cnt;
  logic              r_core_reset;
  logic              r_lock_lost;

  logic              w_locked_s;
  state_t            w_next_state;
  logic [HOLD_W-1:0] w_hold_cnt_next;
  logic              w_set_lost;
  logic              w_run_next;

  assign w_locked_s = r_sync2;

  always_comb begin
    w_next_state    = r_state;
    w_hold_cnt_next = '0;
    w_set_lost      = 1'b0;
    case (r_state)
      WAIT_LOCK: begin
        if (w_locked_s) w_next_state = HOLD;
      end
      HOLD: begin
        if (!w_locked_s) begin
          w_next_state = WAIT_LOCK;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_next_state = RUN;
        end else begin
          w_hold_cnt_next = r_hold_cnt + 1'b1;
        end
      end
      RUN: begin
        if (!w_locked_s) begin
          w_next_state = WAIT_LOCK;
          w_set_lost   = 1'b1;
        end
      end
      default: w_next_state = WAIT_LOCK;
    endcase
  end

  // Enable dividers only count while staying in RUN, so they re-enter RUN at phase 0.
  assign w_run_next = (r_state == RUN) && (w_next_state == RUN);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_state      <= WAIT_LOCK;
      r_hold_cnt   <= '0;
      r_pix_cnt    <= '0;
      r_cpu_cnt    <= '0;
      r_core_reset <= 1'b1;
      r_lock_lost  <= 1'b0;
    end else begin
      r_sync1      <= pll_locked;
      r_sync2      <= r_sync1;
      r_state      <= w_next_state;
      r_hold_cnt   <= w_hold_cnt_next;
      r_core_reset <= (w_next_state != RUN);
      if (w_set_lost) r_lock_lost <= 1'b1;
      if (w_run_next) begin
        r_pix_cnt <= (r_pix_cnt == PIX_LAST) ? '0 : r_pix_cnt + 1'b1;
        r_cpu_cnt <= (r_cpu_cnt == CPU_LAST) ? '0 : r_cpu_cnt + 1'b1;
      end else begin
        r_pix_cnt <= '0;
        r_cpu_cnt <= '0;
      end
    end
  end

  assign core_reset = r_core_reset;
  assign ready      = (r_state == RUN);
  assign ce_pix     = ready && (r_pix_cnt == PIX_LAST);
  assign ce_cpu     = ready && (r_cpu_cnt == CPU_LAST);
  assign lock_lost  = r_lock_lost;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Self-checking bench for clk_rst_seq: two instances (default dividers and
// divide-by-1) compared every cycle against a lock-streak based reference model.
module tb_clk_rst_seq;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll = 1'b0;

  logic coreResetA, readyA, cePixA, ceCpuA, lockLostA;
  logic coreResetB, readyB, cePixB, ceCpuB, lockLostB;

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  // Model: streak = consecutive edges at which the synchronized lock was seen high.
  bit s1 = 1'b0;
  bit s2 = 1'b0;
  int streak = 0;
  bit lockLostM = 1'b0;

  always #5 clk = ~clk;

  clk_rst_seq #(.HOLD_CYCLES(HOLD), .CE_PIX_DIV(3), .CE_CPU_DIV(6)) dutA (
    .clk_sys(clk), .reset(rst), .pll_locked(pll),
    .core_reset(coreResetA), .ready(readyA), .ce_pix(cePixA),
    .ce_cpu(ceCpuA), .lock_lost(lockLostA)
  );

  clk_rst_seq #(.HOLD_CYCLES(HOLD), .CE_PIX_DIV(1), .CE_CPU_DIV(1)) dutB (
    .clk_sys(clk), .reset(rst), .pll_locked(pll),
    .core_reset(coreResetB), .ready(readyB), .ce_pix(cePixB),
    .ce_cpu(ceCpuB), .lock_lost(lockLostB)
  );

  always @(posedge clk) begin
    if (rst) begin
      s1 = 1'b0;
      s2 = 1'b0;
      streak = 0;
      lockLostM = 1'b0;
    end else begin
      if (streak >= HOLD + 1 && !s2) lockLostM = 1'b1;
      if (s2) streak = streak + 1;
      else    streak = 0;
      s2 = s1;
      s1 = pll;
    end
  end

  function automatic bit inRun();
    return streak >= HOLD + 1;
  endfunction

  function automatic bit ceExp(int div);
    return inRun() && (((streak - (HOLD + 1)) % div) == div - 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic p);
    @(negedge clk);
    #1;
    rst = r;
    pll = p;
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("A.core_reset", 32'(coreResetA), 32'(!inRun()));
      checkOutput("A.ready",      32'(readyA),     32'(inRun()));
      checkOutput("A.ce_pix",     32'(cePixA),     32'(ceExp(3)));
      checkOutput("A.ce_cpu",     32'(ceCpuA),     32'(ceExp(6)));
      checkOutput("A.lock_lost",  32'(lockLostA),  32'(lockLostM));
      checkOutput("B.core_reset", 32'(coreResetB), 32'(!inRun()));
      checkOutput("B.ready",      32'(readyB),     32'(inRun()));
      checkOutput("B.ce_pix",     32'(cePixB),     32'(ceExp(1)));
      checkOutput("B.ce_cpu",     32'(ceCpuB),     32'(ceExp(1)));
      checkOutput("B.lock_lost",  32'(lockLostB),  32'(lockLostM));
    end
  end

  // Counts negedges until ready rises; an expired budget is a failed check.
  task automatic waitReady(input string name, output int n);
    n = 0;
    while (readyA !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (readyA !== 1'b1) checkOutput({name, ".timeout"}, 32'(readyA), 32'd1);
  endtask

  initial begin
    int n;
    logic [8:0] pixBits, cpuBits, pixBitsB;

    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkEn = 1'b1;
    checkOutput("rst.core_reset", 32'(coreResetA), 32'd1);
    checkOutput("rst.ready",      32'(readyA),     32'd0);
    checkOutput("rst.ce_pix",     32'(cePixA),     32'd0);
    checkOutput("rst.lock_lost",  32'(lockLostA),  32'd0);
    applyStimulus(1'b0, 1'b0);

    // Lock rises before edge k: core_reset must fall after edge k+2+HOLD.
    applyStimulus(1'b0, 1'b1);
    waitReady("relock", n);
    checkOutput("release.latency", 32'(n), 32'd7);
    checkOutput("release.core_reset", 32'(coreResetA), 32'd0);

    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      pixBits[i]  = cePixA;
      cpuBits[i]  = ceCpuA;
      pixBitsB[i] = cePixB;
    end
    checkOutput("ce_pix.pattern",   32'(pixBits),  32'(9'b100100100));
    checkOutput("ce_cpu.pattern",   32'(cpuBits),  32'(9'b000100000));
    checkOutput("ce_div1.pattern",  32'(pixBitsB), 32'(9'b111111111));

    // One-cycle lock glitch in RUN.
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    checkOutput("glitch.still_run", 32'(readyA), 32'd1);
    @(negedge clk);
    checkOutput("glitch.core_reset", 32'(coreResetA), 32'd1);
    checkOutput("glitch.ready",      32'(readyA),     32'd0);
    checkOutput("glitch.ce_pix",     32'(cePixA),     32'd0);
    checkOutput("glitch.lock_lost",  32'(lockLostA),  32'd1);
    waitReady("glitch_relock", n);
    checkOutput("glitch.lock_lost_sticky", 32'(lockLostA), 32'd1);

    // One-cycle reset pulse in RUN.
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("rstpulse.core_reset", 32'(coreResetA), 32'd1);
    checkOutput("rstpulse.ready",      32'(readyA),     32'd0);
    checkOutput("rstpulse.lock_lost",  32'(lockLostA),  32'd0);

    // Lock drop reaching the FSM while hold_cnt==2, then a full HOLD after relock.
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    waitReady("holddrop", n);
    checkOutput("holddrop.latency",   32'(n),         32'd7);
    checkOutput("holddrop.lock_lost", 32'(lockLostA), 32'd0);

    // Randomized lock segments with occasional resets.
    for (int seg = 0; seg < 300; seg++) begin
      int len;
      logic val;
      len = $urandom_range(1, 25);
      val = ($urandom_range(0, 9) < 7);
      for (int c = 0; c < len; c++)
        applyStimulus(($urandom_range(0, 299) == 0), val);
    end
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);

    checkEn = 1'b0;
    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_rst_seq.md
CLK_RST_SEQ -- requirements
Module: clk_rst_seq

Interface
REQ-001 Parameter HOLD_CYCLES, default 1024: clk_sys cycles for which a synchronized lock must persist before core reset releases; legal range >= 1.
REQ-002 Parameter CE_PIX_DIV, default 3: clk_sys division ratio for ce_pix (6 MHz from 18 MHz); legal range >= 1.
REQ-003 Parameter CE_CPU_DIV, default 6: clk_sys division ratio for ce_cpu (3 MHz from 18 MHz); legal range >= 1.
REQ-004 clk_sys  in  1  core clock, driven by the 18 MHz PLL output; the only clock in the block.
REQ-005 reset  in  1  synchronous, active-high reset, sampled on the clk_sys rising edge.
REQ-006 pll_locked  in  1  PLL lock indicator, asynchronous to clk_sys.
REQ-007 core_reset  out  1  registered, active-high reset to the game core.
REQ-008 ready  out  1  high only while the sequencer is in RUN.
REQ-009 ce_pix  out  1  single-cycle pixel clock enable.
REQ-010 ce_cpu  out  1  single-cycle CPU clock enable.
REQ-011 lock_lost  out  1  sticky flag: lock dropped while in RUN.

Function
REQ-012 pll_locked SHALL pass through a two-flop synchronizer to produce locked_s; no other logic SHALL sample pll_locked.
REQ-013 The FSM SHALL have exactly three states: WAIT_LOCK, HOLD and RUN.
REQ-014 WAIT_LOCK: when locked_s=1, the next state SHALL be HOLD with hold_cnt=0; otherwise the FSM SHALL remain in WAIT_LOCK.
REQ-015 HOLD: if locked_s=0, the next state SHALL be WAIT_LOCK; otherwise, if hold_cnt==HOLD_CYCLES-1, the next state SHALL be RUN; otherwise hold_cnt SHALL increment by 1.
REQ-016 RUN: if locked_s=0, the next state SHALL be WAIT_LOCK and lock_lost SHALL be set to 1 at the same edge.
REQ-017 hold_cnt SHALL be clog2(HOLD_CYCLES+1) bits wide, SHALL never wrap, and SHALL be held at 0 outside HOLD.
REQ-018 core_reset SHALL be a register loaded at each edge with (next_state != RUN); ready SHALL equal (state == RUN).
REQ-019 Latency: if pll_locked is stable high before edge k, locked_s SHALL be 1 after edge k+1, state SHALL be HOLD after edge k+2, and core_reset SHALL fall after edge k+2+HOLD_CYCLES.
REQ-020 pix_cnt and cpu_cnt SHALL be held at 0 outside RUN, SHALL increment each RUN cycle, and SHALL wrap from DIV-1 to 0.
REQ-021 ce_pix SHALL equal (state==RUN && pix_cnt==CE_PIX_DIV-1); ce_cpu SHALL be defined the same way using cpu_cnt and CE_CPU_DIV.
REQ-022 Counting RUN cycles from 0, ce_pix SHALL first assert in cycle CE_PIX_DIV-1 and then every CE_PIX_DIV cycles; ce_cpu SHALL follow the same rule with CE_CPU_DIV.
REQ-023 When DIV=1, the corresponding ce output SHALL be constantly 1 during RUN.
REQ-024 Both ce outputs SHALL be 0 in WAIT_LOCK and HOLD, and in every cycle where core_reset=1.
REQ-025 A lock drop of any length that is captured by the synchronizer SHALL restart the full HOLD sequence; there is no partial credit.
REQ-026 lock_lost SHALL be cleared only by reset.

Reset
REQ-027 reset=1 SHALL force, at the next edge: state=WAIT_LOCK, both synchronizer flops=0, all counters=0, core_reset=1, ready=0, ce_pix=0, ce_cpu=0, lock_lost=0.
REQ-028 reset SHALL take priority over every other event; reset together with a lock drop in RUN SHALL leave lock_lost=0.
REQ-029 reset asserted mid-HOLD or mid-RUN SHALL abort immediately, and the sequence SHALL restart from WAIT_LOCK once reset=0.

Verification
REQ-030 HOLD_CYCLES=4, reset released, pll_locked high before edge 10 -> core_reset falls after edge 16; ready=1 from the same edge.
REQ-031 In RUN with defaults -> ce_pix high in RUN cycles 2,5,8,...; ce_cpu high in RUN cycles 5,11,17,...; each pulse exactly one cycle wide.
REQ-032 In RUN, pll_locked low for 1 cycle -> two edges later state=WAIT_LOCK, core_reset=1, ce outputs=0, lock_lost=1; lock_lost stays 1 after lock returns and RUN is re-entered.
REQ-033 HOLD_CYCLES=4, lock drops when hold_cnt=2 -> return to WAIT_LOCK; core_reset stays 1 until a full 4-cycle HOLD completes after relock; lock_lost stays 0.
REQ-034 reset pulsed for 1 cycle during RUN -> the following cycle core_reset=1, ready=0, lock_lost=0; RUN is re-entered HOLD_CYCLES+2 cycles after reset falls.
REQ-035 CE_PIX_DIV=1, CE_CPU_DIV=1 -> both ce outputs are 1 in every RUN cycle and 0 otherwise.
